// File: rtl/fft_pkg.sv
// Shared types for the fft_8 front end: sample format, frame geometry and the
// loader's output-sequencer states.
package fft_pkg;

  localparam int DW    = 16;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_START   = 2'd2,
    ST_WAIT    = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One 8-entry complex sample buffer with a frame-complete flag.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_idx,
  input  cplx_t             wr_data,
  input  logic              set_full,
  input  logic              clr_full,
  output cplx_t [N-1:0]     entries,
  output logic              full
);

  cplx_t [N-1:0] entries_q, entries_d;
  logic          full_q, full_d;

  always_comb begin
    entries_d = entries_q;
    full_d    = full_q;
    if (wr_en) entries_d[wr_idx] = wr_data;
    if (set_full)      full_d = 1'b1;
    else if (clr_full) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      full_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      full_q    <= full_d;
    end
  end

  assign entries = entries_q;
  assign full    = full_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Streams complex samples into ping-pong frame banks and hands each finished
// frame to fft_8 in parallel, sequencing its write/start controls.
module fft_frame_loader #(
  parameter int DW = 16,
  parameter int N  = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  input  logic          s_last,
  input  logic          fft_ready,
  output logic          write,
  output logic          start,
  output logic [DW-1:0] inwr1,
  output logic [DW-1:0] inwr2,
  output logic [DW-1:0] inwr3,
  output logic [DW-1:0] inwr4,
  output logic [DW-1:0] inwr5,
  output logic [DW-1:0] inwr6,
  output logic [DW-1:0] inwr7,
  output logic [DW-1:0] inwr8,
  output logic [DW-1:0] inwc1,
  output logic [DW-1:0] inwc2,
  output logic [DW-1:0] inwc3,
  output logic [DW-1:0] inwc4,
  output logic [DW-1:0] inwc5,
  output logic [DW-1:0] inwc6,
  output logic [DW-1:0] inwc7,
  output logic [DW-1:0] inwc8,
  output logic          frame_err,
  output logic [15:0]   frames_out,
  output logic [1:0]    dbg_state
);
  import fft_pkg::*;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  ldr_state_t       state_q, state_d;
  logic             wbank_q, wbank_d, rbank_q, rbank_d;
  logic [LOG2N-1:0] widx_q, widx_d;
  logic             seen_low_q, seen_low_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      frames_out_q, frames_out_d;
  cplx_t [N-1:0]    frame_q, frame_d;

  cplx_t [N-1:0]    bank_data [2];
  logic [1:0]       full, bank_wr, bank_set, bank_clr;
  logic             accept, short_last, frame_done, write_c, start_c;
  cplx_t            sample;

  // Stream handshake: a sample transfers on every rising edge where
  // s_valid && s_ready; s_ready depends only on the fill bank's full flag,
  // never on s_valid, and the source must hold data steady until it transfers.
  assign s_ready    = !full[wbank_q];
  assign accept     = s_valid && s_ready;
  assign short_last = accept && s_last && (widx_q != LAST_IDX);
  assign frame_done = accept && (widx_q == LAST_IDX);
  assign sample     = cplx_t'{re: s_re, im: s_im};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk      (CLK),
      .rst      (RST),
      .wr_en    (bank_wr[b]),
      .wr_idx   (widx_q),
      .wr_data  (sample),
      .set_full (bank_set[b]),
      .clr_full (bank_clr[b]),
      .entries  (bank_data[b]),
      .full     (full[b])
    );
  end

  always_comb begin
    bank_wr      = '0;
    bank_set     = '0;
    bank_clr     = '0;
    wbank_d      = wbank_q;
    widx_d       = widx_q;
    frame_err_d  = 1'b0;
    state_d      = state_q;
    rbank_d      = rbank_q;
    seen_low_d   = seen_low_q;
    frames_out_d = frames_out_q;
    frame_d      = frame_q;
    write_c      = 1'b0;
    start_c      = 1'b0;

    // An early s_last drops the partial frame; the bank is simply refilled.
    if (short_last) begin
      widx_d      = '0;
      frame_err_d = 1'b1;
    end else if (accept) begin
      bank_wr[wbank_q] = 1'b1;
      if (frame_done) begin
        bank_set[wbank_q] = 1'b1;
        wbank_d           = !wbank_q;
        widx_d            = '0;
      end else begin
        widx_d = widx_q + LOG2N'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (full[rbank_q] && fft_ready) begin
          state_d = ST_PRESENT;
          frame_d = bank_data[rbank_q];
        end
      end
      ST_PRESENT: begin
        write_c = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        write_c           = 1'b1;
        start_c           = 1'b1;
        bank_clr[rbank_q] = 1'b1;
        rbank_d           = !rbank_q;
        frames_out_d      = frames_out_q + 16'd1;
        // A core that drops ready on the start edge itself must still count.
        seen_low_d        = !fft_ready;
        state_d           = ST_WAIT;
      end
      ST_WAIT: begin
        seen_low_d = seen_low_q || !fft_ready;
        if (seen_low_q && fft_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      widx_q       <= '0;
      seen_low_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      frames_out_q <= '0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      widx_q       <= widx_d;
      seen_low_q   <= seen_low_d;
      frame_err_q  <= frame_err_d;
      frames_out_q <= frames_out_d;
      frame_q      <= frame_d;
    end
  end

  assign write      = write_c && !RST;
  assign start      = start_c && !RST;
  assign frame_err  = frame_err_q;
  assign frames_out = frames_out_q;
  assign dbg_state  = state_q;

  assign inwr1 = frame_q[0].re;
  assign inwr2 = frame_q[1].re;
  assign inwr3 = frame_q[2].re;
  assign inwr4 = frame_q[3].re;
  assign inwr5 = frame_q[4].re;
  assign inwr6 = frame_q[5].re;
  assign inwr7 = frame_q[6].re;
  assign inwr8 = frame_q[7].re;
  assign inwc1 = frame_q[0].im;
  assign inwc2 = frame_q[1].im;
  assign inwc3 = frame_q[2].im;
  assign inwc4 = frame_q[3].im;
  assign inwc5 = frame_q[4].im;
  assign inwc6 = frame_q[5].im;
  assign inwc7 = frame_q[6].im;
  assign inwc8 = frame_q[7].im;

endmodule
